// File: rtl/ram_sdp_be_if.sv
// Write/read bus of the simple dual-port byte-enable RAM.
// master drives requests; slave (the RAM) returns ready and read results.
interface ram_sdp_be_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_WORDS    = 16,
    parameter int BYTE_WIDTH = 8
);
    localparam int AW = $clog2(N_WORDS);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  ready;
    logic                  we;
    logic [AW-1:0]         wr_addr;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  re;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        input  ready, rd_data, rd_valid,
        output we, wr_addr, wr_be, wr_data, re, rd_addr
    );

    modport slave (
        output ready, rd_data, rd_valid,
        input  we, wr_addr, wr_be, wr_data, re, rd_addr
    );
endinterface

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte-lane writes and optional zero-fill after reset.
// Latency: write commits at the edge; read data/valid registered, 1 cycle after re.
// Backpressure: ready low during zero-fill; requests are ignored, never queued.
module ram_sdp_be #(
    parameter int DATA_WIDTH     = 8,
    parameter int N_WORDS        = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_FIRST     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sdp_be_if.slave   bus
);
    localparam int              AW    = $clog2(N_WORDS);
    localparam int              NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [AW:0]     DEPTH = (AW+1)'(N_WORDS);
    localparam logic [AW-1:0]   LAST  = AW'(N_WORDS - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         clr_cnt_q;
    logic                  clearing, idle;
    logic                  wr_ok, rd_ok, rd_in_range, collide;
    logic [DATA_WIDTH-1:0] rd_old, rd_word;
    logic [DATA_WIDTH-1:0] mem [N_WORDS];

    assign clearing    = (state_q == S_CLEAR);
    assign idle        = (state_q == S_IDLE);
    assign bus.ready   = idle;
    assign wr_ok       = idle && bus.we && ({1'b0, bus.wr_addr} < DEPTH);
    assign rd_ok       = idle && bus.re;
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH);
    assign collide     = wr_ok && bus.re && (bus.wr_addr == bus.rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (clearing) clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clearing && (clr_cnt_q == LAST)) state_d = S_IDLE;
    end

    // Array has no reset; zero-fill walks it one word per edge instead.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wr_be[i])
                    mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Write-first forwards enabled lanes of the colliding write over the stored word.
    always_comb begin
        rd_old  = rd_in_range ? mem[bus.rd_addr] : '0;
        rd_word = rd_old;
        if ((READ_FIRST == 0) && collide) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wr_be[i])
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= rd_ok;
            if (rd_ok) bus.rd_data <= rd_word;
        end
    end
endmodule

// File: tb/tb_ram_sdp_be.sv
// Two RAM instances share one stimulus stream: 32-bit/16-word write-first and
// 8-bit/12-word read-first, each checked against its own array model.
module tb_ram_sdp_be;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [3:0]  wa = '0, ra = '0, be = '0;
    logic [31:0] wd = '0;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] m0 [16];
    logic [7:0]  m1 [12];
    logic [31:0] exp_d0;
    logic [7:0]  exp_d1;
    logic        exp_v0, exp_v1;

    always #5 clk = ~clk;

    ram_sdp_be_if #(.DATA_WIDTH(32), .N_WORDS(16), .BYTE_WIDTH(8)) if0 ();
    ram_sdp_be_if #(.DATA_WIDTH(8),  .N_WORDS(12), .BYTE_WIDTH(8)) if1 ();

    assign if0.we = we;  assign if0.wr_addr = wa; assign if0.wr_be = be;      assign if0.wr_data = wd;
    assign if0.re = re;  assign if0.rd_addr = ra;
    assign if1.we = we;  assign if1.wr_addr = wa; assign if1.wr_be = be[0];   assign if1.wr_data = wd[7:0];
    assign if1.re = re;  assign if1.rd_addr = ra;

    ram_sdp_be #(.DATA_WIDTH(32), .N_WORDS(16), .BYTE_WIDTH(8), .READ_FIRST(0), .CLEAR_ON_RESET(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ram_sdp_be #(.DATA_WIDTH(8), .N_WORDS(12), .BYTE_WIDTH(8), .READ_FIRST(1), .CLEAR_ON_RESET(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic model_zero();
        for (int i = 0; i < 16; i++) m0[i] = '0;
        for (int i = 0; i < 12; i++) m1[i] = '0;
        exp_d0 = '0; exp_d1 = '0; exp_v0 = 1'b0; exp_v1 = 1'b0;
    endtask

    // One IDLE-mode cycle: drive, let the edge pass, update expectations from the array models.
    task automatic cycle(input logic w, input logic [3:0] aw, input logic [3:0] b,
                         input logic [31:0] d, input logic r, input logic [3:0] ar);
        logic [31:0] word0;
        @(negedge clk);
        we = w; wa = aw; be = b; wd = d; re = r; ra = ar;
        @(posedge clk);
        exp_v0 = r;
        exp_v1 = r;
        if (r) begin
            word0 = m0[ar];
            if (w && aw == ar)
                for (int i = 0; i < 4; i++) if (b[i]) word0[i*8 +: 8] = d[i*8 +: 8];
            exp_d0 = word0;
            exp_d1 = (ar < 12) ? m1[ar] : 8'h00;
        end
        if (w) begin
            for (int i = 0; i < 4; i++) if (b[i]) m0[aw][i*8 +: 8] = d[i*8 +: 8];
            if (aw < 12 && b[0]) m1[aw] = d[7:0];
        end
        #1;
    endtask

    task automatic check_both(input string tag);
        n_chk++;
        if (if0.rd_valid !== exp_v0 || (exp_v0 && if0.rd_data !== exp_d0) || if0.rd_data !== exp_d0) begin
            $display("FAIL %s dut0: valid=%0b data=%h, required valid=%0b data=%h",
                     tag, if0.rd_valid, if0.rd_data, exp_v0, exp_d0);
        end else n_pass++;
        n_chk++;
        if (if1.rd_valid !== exp_v1 || if1.rd_data !== exp_d1) begin
            $display("FAIL %s dut1: valid=%0b data=%h, required valid=%0b data=%h",
                     tag, if1.rd_valid, if1.rd_data, exp_v1, exp_d1);
        end else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (if0.ready !== 1'b0 || if1.ready !== 1'b0 || if0.rd_valid !== 1'b0 || if1.rd_valid !== 1'b0 ||
            if0.rd_data !== 32'h0 || if1.rd_data !== 8'h0)
            $display("FAIL reset_state: ready=%b%b valid=%b%b data=%h/%h, required all 0",
                     if0.ready, if1.ready, if0.rd_valid, if1.rd_valid, if0.rd_data, if1.rd_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b1; wa = 4'd3; be = 4'hF; wd = 32'h0000_00AA; re = 1'b1; ra = 4'd3;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (if0.ready !== (e >= 16) || if1.ready !== (e >= 12))
                $display("FAIL clear_ready edge %0d: ready0=%b ready1=%b, required %b %b",
                         e, if0.ready, if1.ready, e >= 16, e >= 12);
            else n_pass++;
            n_chk++;
            if (if0.rd_valid !== 1'b0 || (e <= 12 && if1.rd_valid !== 1'b0))
                $display("FAIL clear_no_read edge %0d: valid0=%b valid1=%b, required 0", e, if0.rd_valid, if1.rd_valid);
            else n_pass++;
            if (e == 12) begin
                @(negedge clk);
                we = 1'b0; re = 1'b0;
            end
        end
        model_zero();
        for (int a = 0; a < 16; a++) begin
            cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a));
            n_chk++;
            if (if0.rd_data !== 32'h0 || if1.rd_data !== 8'h0 || if0.rd_valid !== 1'b1 || if1.rd_valid !== 1'b1)
                $display("FAIL clear_zero addr %0d: data=%h/%h valid=%b%b, required 0/0 valid 11",
                         a, if0.rd_data, if1.rd_data, if0.rd_valid, if1.rd_valid);
            else n_pass++;
        end
    endtask

    task automatic test_byte_en();
        cycle(1'b1, 4'd5, 4'b1111, 32'h1122_3344, 1'b0, 4'd0);
        cycle(1'b1, 4'd5, 4'b0101, 32'hAABB_CCDD, 1'b0, 4'd0);
        cycle(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd5);
        n_chk++;
        if (if0.rd_valid !== 1'b1 || if0.rd_data !== 32'h11BB_33DD || if1.rd_data !== 8'hDD)
            $display("FAIL byte_en: valid=%b data=%h/%h, required 1 11bb33dd/dd", if0.rd_valid, if0.rd_data, if1.rd_data);
        else n_pass++;
        check_both("byte_en_model");
        cycle(1'b1, 4'd5, 4'b0000, 32'hFFFF_FFFF, 1'b0, 4'd0);
        check_both("valid_drop_hold");
        cycle(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd5);
        check_both("be_zero_no_change");
    endtask

    task automatic test_collision();
        cycle(1'b1, 4'd2, 4'hF, 32'h0000_000F, 1'b0, 4'd0);
        cycle(1'b1, 4'd2, 4'hF, 32'h0000_00F0, 1'b1, 4'd2);
        n_chk++;
        if (if0.rd_data !== 32'h0000_00F0 || if1.rd_data !== 8'h0F)
            $display("FAIL collision: data=%h/%h, required 000000f0/0f", if0.rd_data, if1.rd_data);
        else n_pass++;
        cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2);
        n_chk++;
        if (if0.rd_data !== 32'h0000_00F0 || if1.rd_data !== 8'hF0)
            $display("FAIL collision_after: data=%h/%h, required 000000f0/f0", if0.rd_data, if1.rd_data);
        else n_pass++;
        cycle(1'b1, 4'd2, 4'b0110, 32'h1234_5678, 1'b1, 4'd2);
        check_both("collision_partial");
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++) cycle(1'b1, 4'(a), 4'hF, 32'(a * 3), 1'b0, 4'd0);
        for (int a = 0; a < 16; a++) begin
            cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a));
            n_chk++;
            if (if0.rd_valid !== 1'b1 || if0.rd_data !== 32'(a * 3))
                $display("FAIL stream addr %0d: valid=%b data=%h, required 1 %h", a, if0.rd_valid, if0.rd_data, 32'(a * 3));
            else n_pass++;
            check_both("stream_model");
        end
        cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
        check_both("stream_end");
    endtask

    task automatic test_out_of_range();
        cycle(1'b1, 4'd13, 4'hF, 32'h0000_0055, 1'b0, 4'd0);
        cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd13);
        n_chk++;
        if (if1.rd_valid !== 1'b1 || if1.rd_data !== 8'h00 || if0.rd_data !== 32'h55)
            $display("FAIL oor_read13: valid1=%b data=%h/%h, required 1 00000055/00", if1.rd_valid, if0.rd_data, if1.rd_data);
        else n_pass++;
        cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd11);
        n_chk++;
        if (if1.rd_data !== 8'd33)
            $display("FAIL oor_keep11: data=%h, required 21", if1.rd_data);
        else n_pass++;
        check_both("oor_model");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            check_both("random");
        end
        cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd4);
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (if0.ready !== 1'b0 || if1.ready !== 1'b0 || if0.rd_valid !== 1'b0 || if0.rd_data !== 32'h0 || if1.rd_data !== 8'h0)
            $display("FAIL reset_async: ready=%b%b valid0=%b data=%h/%h, required 0", if0.ready, if1.ready,
                     if0.rd_valid, if0.rd_data, if1.rd_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (if0.ready !== 1'b0 || if0.rd_valid !== 1'b0 || if0.rd_data !== 32'h0)
            $display("FAIL reset_mid: ready=%b valid=%b data=%h, required 0", if0.ready, if0.rd_valid, if0.rd_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (if0.ready !== (e >= 16) || if1.ready !== (e >= 12))
                $display("FAIL reclear_ready edge %0d: ready0=%b ready1=%b, required %b %b",
                         e, if0.ready, if1.ready, e >= 16, e >= 12);
            else n_pass++;
        end
        model_zero();
        for (int a = 0; a < 16; a++) begin
            cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a));
            check_both("reclear_zero");
        end
    endtask

    initial begin
        test_reset();
        test_byte_en();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
